// File: rtl/ifetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue_if
// Description : Bundle of the fetch-queue bus signals.
//               master modport : the fetch queue itself
//                 in  redirect_valid, redirect_pc[15:0]  branch/jump redirect
//                 out imem_req, imem_addr[15:0]          memory read request
//                 in  imem_rdata[15:0]                   read data, 1 cycle later
//                 out out_valid, out_instr, out_pc,
//                     out_pc2                            head of queue to decode
//                 in  out_ready                          decode accepts head
//                 out perf_stall, perf_flush             optional counters
//               slave modport  : the surrounding core / memory / decode
// Revision    : 1.0  initial release
// ============================================================================
interface ifetch_queue_if;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc2;
  logic [15:0] perf_stall;
  logic [15:0] perf_flush;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc2,
           perf_stall, perf_flush
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc2,
           perf_stall, perf_flush
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction-fetch front end. Owns the fetch PC, issues reads
//               to a 1-cycle-latency synchronous instruction memory, buffers
//               {instr, pc} pairs in a DEPTH-entry FIFO and presents the head
//               to decode over valid/ready. A redirect flushes the FIFO and
//               squashes any in-flight read.
// Ports       : clk, rst (sync, active-high) plus ifetch_queue_if.master bus.
// Parameters  : DEPTH (power of two, 2..16), PC_RESET, PC_STEP.
// Options     : define IFQ_PERF_EN to build the perf_stall / perf_flush
//               saturating counters; otherwise both outputs are tied to 0.
// Revision    : 1.0  initial release
// ============================================================================
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [15:0]      inflight_pc_q, inflight_pc_d;
  logic [15:0]      fifo_instr_q [DEPTH];
  logic [15:0]      fifo_instr_d [DEPTH];
  logic [15:0]      fifo_pc_q [DEPTH];
  logic [15:0]      fifo_pc_d [DEPTH];

  logic             head_valid;
  logic             issue;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occupancy;
  logic             unused_pc_lsb;

  // Credit counts both buffered entries and the read already in flight, so
  // every issued read is guaranteed a FIFO slot when it returns.
  assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue      = !rst && !bus.redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  assign head_valid = !rst && (count_q != '0);
  assign pop        = head_valid && bus.out_ready;
  assign push       = inflight_q && !bus.redirect_valid;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = head_valid ? fifo_instr_q[rd_ptr_q] : 16'd0;
  assign bus.out_pc    = head_valid ? fifo_pc_q[rd_ptr_q]    : 16'd0;
  assign bus.out_pc2   = bus.out_pc + PC_STEP;

  // Redirect targets are halfword aligned; bit 0 is dropped.
  assign unused_pc_lsb = bus.redirect_pc[0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;

    if (bus.redirect_valid) begin
      // A same-cycle pop has already been handed to decode; everything else
      // (buffered entries and the in-flight return) is stale.
      fetch_pc_d = {bus.redirect_pc[15:1], 1'b0};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + PC_STEP;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = bus.imem_rdata;
        fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d               = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= PC_RESET;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'd0;
      fifo_instr_q  <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
    end
  end

`ifdef IFQ_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;
  logic        flush_drops;

  // A redirect only counts as a flush if it throws something away: an entry
  // left behind after the same-cycle pop, or a pending memory return.
  assign flush_drops = bus.redirect_valid &&
                       ((count_q > {{(CNT_W-1){1'b0}}, pop}) || inflight_q);

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (head_valid && !bus.out_ready && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
    if (flush_drops && (perf_flush_q != 16'hFFFF)) begin
      perf_flush_d = perf_flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 16'd0;
      perf_flush_q <= 16'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_flush = perf_flush_q;
`else
  assign bus.perf_stall = 16'd0;
  assign bus.perf_flush = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue. A behavioural model
//               (SV queue of {instr, pc}, fetch PC, pending-read flag) predicts
//               every output each cycle; directed scenarios cover reset,
//               backpressure, redirects, PC wrap and the perf counters, then
//               a randomized phase mixes ready, redirects and resets.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch_queue;
  localparam int DEPTH = 4;
`ifdef IFQ_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .PC_RESET (16'h0000),
    .PC_STEP  (16'd2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  // Synchronous instruction memory; garbage on cycles without a request.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
    else              bus.imem_rdata <= 16'($urandom);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  ent_t        mq[$];
  logic [15:0] m_fpc = 16'h0000;
  logic [15:0] m_ipc = 16'h0000;
  bit          m_infl = 1'b0;
  int          m_stall = 0;
  int          m_flush = 0;
  bit          e_req, e_valid;

  // Observed outputs of the most recent cycle
  logic        o_req, o_valid;
  logic [15:0] o_addr, o_instr, o_pc, o_pc2, o_stall, o_flush;

  task automatic cycle(input bit r, input bit rv, input logic [15:0] rpc, input bit rdy);
    bit pop;
    int lost;
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    @(negedge clk);
    o_req   = bus.imem_req;
    o_addr  = bus.imem_addr;
    o_valid = bus.out_valid;
    o_instr = bus.out_instr;
    o_pc    = bus.out_pc;
    o_pc2   = bus.out_pc2;
    o_stall = bus.perf_stall;
    o_flush = bus.perf_flush;

    e_req   = !r && !rv && ((mq.size() + int'(m_infl)) < DEPTH);
    e_valid = !r && (mq.size() != 0);
    chk("imem_req", 32'(o_req), 32'(e_req));
    chk("out_valid", 32'(o_valid), 32'(e_valid));
    if (e_req) chk("imem_addr", 32'(o_addr), 32'(m_fpc));
    if (e_valid) begin
      chk("out_instr", 32'(o_instr), 32'(mq[0].instr));
      chk("out_pc", 32'(o_pc), 32'(mq[0].pc));
      chk("out_pc2", 32'(o_pc2), 32'(16'(mq[0].pc + 16'd2)));
    end
    if (r) begin
      chk("rst_instr", 32'(o_instr), 32'd0);
      chk("rst_pc", 32'(o_pc), 32'd0);
    end
    chk("perf_stall", 32'(o_stall), PERF_EN ? 32'(m_stall) : 32'd0);
    chk("perf_flush", 32'(o_flush), PERF_EN ? 32'(m_flush) : 32'd0);
    if (!r && !rv && dut.inflight_q)
      chk("no_overflow_push", 32'(dut.count_q < DEPTH), 32'd1);

    @(posedge clk);
    if (r) begin
      mq.delete();
      m_fpc   = 16'h0000;
      m_infl  = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      pop = e_valid && rdy;
      if (e_valid && !rdy && m_stall < 65535) m_stall++;
      if (rv) begin
        lost = mq.size() - int'(pop) + int'(m_infl);
        if (lost > 0 && m_flush < 65535) m_flush++;
        mq.delete();
        m_infl = 1'b0;
        m_fpc  = rpc & 16'hFFFE;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_infl) mq.push_back('{instr: mem_word(m_ipc), pc: m_ipc});
        if (e_req) begin
          m_ipc = m_fpc;
          m_fpc = m_fpc + 16'd2;
        end
        m_infl = e_req;
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int nreq, k;
    bit found;
    logic [15:0] exp5 [3];
    exp5[0] = 16'hFFFC; exp5[1] = 16'hFFFE; exp5[2] = 16'h0000;

    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    bus.out_ready      = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset release with decode always ready
    repeat (3) cycle(1, 0, 16'h0, 1);
    cycle(0, 0, 16'h0, 1);
    chk("t1_c1_req", 32'(o_req), 32'd1);
    chk("t1_c1_addr", 32'(o_addr), 32'h0000);
    cycle(0, 0, 16'h0, 1);
    cycle(0, 0, 16'h0, 1);
    chk("t1_c3_valid", 32'(o_valid), 32'd1);
    chk("t1_c3_instr", 32'(o_instr), 32'h1000);
    chk("t1_c3_pc", 32'(o_pc), 32'h0000);
    chk("t1_c3_pc2", 32'(o_pc2), 32'h0002);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 16'h0, 1);
      chk("t1_stream_pc", 32'(o_pc), 32'(2 * i));
    end

    // 2: backpressure after reset
    repeat (2) cycle(1, 0, 16'h0, 0);
    nreq = 0;
    repeat (20) begin
      cycle(0, 0, 16'h0, 0);
      nreq += int'(o_req);
    end
    chk("t2_req_count", 32'(nreq), 32'd4);
    chk("t2_req_idle", 32'(o_req), 32'd0);
    k = 0;
    for (int i = 0; i < 20 && k < 6; i++) begin
      cycle(0, 0, 16'h0, 1);
      if (o_valid) begin
        chk("t2_order", 32'(o_pc), 32'(2 * k));
        k++;
      end
    end
    chk("t2_delivered", 32'(k), 32'd6);

    // 3: redirect with three entries buffered and a read in flight
    repeat (2) cycle(1, 0, 16'h0, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mq.size() == 3 && m_infl) found = 1'b1;
      else cycle(0, 0, 16'h0, 0);
    end
    chk("t3_setup", 32'(found), 32'd1);
    cycle(0, 1, 16'h0041, 0);
    cycle(0, 0, 16'h0, 1);
    chk("t3_valid_drop", 32'(o_valid), 32'd0);
    chk("t3_req", 32'(o_req), 32'd1);
    chk("t3_addr", 32'(o_addr), 32'h0040);
    cycle(0, 0, 16'h0, 1);
    chk("t3_c2_valid", 32'(o_valid), 32'd0);
    cycle(0, 0, 16'h0, 1);
    chk("t3_c3_valid", 32'(o_valid), 32'd1);
    chk("t3_c3_pc", 32'(o_pc), 32'h0040);

    // 4: redirect coinciding with an accepted pop of 0x0010
    repeat (2) cycle(1, 0, 16'h0, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() != 0 && mq[0].pc == 16'h0010) found = 1'b1;
      else cycle(0, 0, 16'h0, 1);
    end
    chk("t4_setup", 32'(found), 32'd1);
    cycle(0, 1, 16'h0200, 1);
    chk("t4_pop_valid", 32'(o_valid), 32'd1);
    chk("t4_pop_pc", 32'(o_pc), 32'h0010);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle(0, 0, 16'h0, 1);
      if (o_valid) begin
        found = 1'b1;
        chk("t4_next_pc", 32'(o_pc), 32'h0200);
      end
    end
    chk("t4_next_seen", 32'(found), 32'd1);

    // 5: PC wrap
    cycle(0, 1, 16'hFFFC, 1);
    k = 0;
    for (int i = 0; i < 10 && k < 3; i++) begin
      cycle(0, 0, 16'h0, 1);
      if (o_valid) begin
        chk("t5_wrap_pc", 32'(o_pc), 32'(exp5[k]));
        if (o_pc == 16'hFFFE) chk("t5_wrap_pc2", 32'(o_pc2), 32'h0000);
        k++;
      end
    end
    chk("t5_delivered", 32'(k), 32'd3);

    // 6: seven stall cycles then two flushing redirects
    repeat (2) cycle(1, 0, 16'h0, 1);
    repeat (9) cycle(0, 0, 16'h0, 0);
    cycle(0, 1, 16'h0100, 1);
    cycle(0, 0, 16'h0, 1);
    cycle(0, 1, 16'h0300, 1);
    cycle(0, 0, 16'h0, 1);
    chk("t6_perf_stall", 32'(o_stall), PERF_EN ? 32'd7 : 32'd0);
    chk("t6_perf_flush", 32'(o_flush), PERF_EN ? 32'd2 : 32'd0);

    // 7: randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r, rv, rdy;
      logic [15:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                         : 16'($urandom);
      cycle(r, rv, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
